// File: rtl/note_tone_synth_if.sv
// Sample stream from the tone synthesiser to the audio codec FIFO.
// The producer holds out_sample steady while out_valid is high and out_ready is low.
interface note_tone_synth_if #(
    parameter int SAMPLE_W = 24
);
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_sample;

    modport master (output out_valid, output out_sample, input  out_ready);
    modport slave  (input  out_valid, input  out_sample, output out_ready);
endinterface

// File: rtl/note_tone_synth.sv
// Square-wave tone generator with a linear attack/release envelope.
// Produces a buzzer bit and signed PCM samples on a valid/ready stream.
module note_tone_synth #(
    parameter int SAMPLE_W   = 24,
    parameter int AMP_SHIFT  = 18,
    parameter int SAMPLE_DIV = 1042,
    parameter int ENV_DIV    = 50000,
    parameter int MIN_PERIOD = 16
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [18:0]             note_period,
    input  logic [3:0]              volume,
    note_tone_synth_if.master       smp,
    output logic                    tone_sq,
    output logic                    tone_active,
    output logic [7:0]              overrun_cnt
);
    localparam int SMP_CW = $clog2(SAMPLE_DIV + 1);
    localparam int ENV_CW = $clog2(ENV_DIV + 1);

    logic [18:0]         p_in;
    logic [18:0]         p_cur;
    logic [18:0]         half_cnt;
    logic                phase;
    logic [3:0]          amp;
    logic [3:0]          target;
    logic [SMP_CW-1:0]   smp_div;
    logic [ENV_CW-1:0]   env_div;
    logic                smp_tick;
    logic                env_step;
    logic                accept;
    logic [SAMPLE_W-1:0] mag;
    logic [SAMPLE_W-1:0] value;

    // Codes too short to be audible are folded into a rest.
    assign p_in     = (note_period < 19'(MIN_PERIOD)) ? 19'd0 : note_period;
    assign tone_sq     = phase;
    assign tone_active = (p_cur != 19'd0);
    assign target   = tone_active ? volume : 4'd0;
    assign smp_tick = (smp_div == SMP_CW'(SAMPLE_DIV - 1));
    assign env_step = (env_div == ENV_CW'(ENV_DIV - 1));
    assign accept   = smp.out_valid && smp.out_ready;
    assign mag      = SAMPLE_W'(amp) << AMP_SHIFT;
    assign value    = phase ? mag : -mag;

    // NOTE: every register below is updated with <= so all reads see the
    // pre-edge values, no matter the statement order inside the block.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            p_cur          <= '0;
            half_cnt       <= '0;
            phase          <= 1'b0;
            amp            <= '0;
            smp_div        <= '0;
            env_div        <= '0;
            smp.out_valid  <= 1'b0;
            smp.out_sample <= '0;
            overrun_cnt    <= '0;
        end else begin
            // Pitch and rest changes are only taken at a half-cycle boundary.
            if (p_cur == 19'd0) begin
                half_cnt <= '0;
                phase    <= 1'b0;
                p_cur    <= p_in;
            end else if (half_cnt == p_cur - 19'd1) begin
                half_cnt <= '0;
                p_cur    <= p_in;
                phase    <= (p_in == 19'd0) ? 1'b0 : ~phase;
            end else begin
                half_cnt <= half_cnt + 19'd1;
            end

            env_div <= env_step ? '0 : env_div + ENV_CW'(1);
            if (env_step) begin
                if (amp < target)      amp <= amp + 4'd1;
                else if (amp > target) amp <= amp - 4'd1;
            end

            smp_div <= smp_tick ? '0 : smp_div + SMP_CW'(1);

            // A tick coinciding with an accept reloads without a bubble.
            if (smp_tick && (!smp.out_valid || accept)) begin
                smp.out_sample <= value;
                smp.out_valid  <= 1'b1;
            end else if (accept) begin
                smp.out_valid  <= 1'b0;
            end

            if (smp_tick && smp.out_valid && !smp.out_ready && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_note_tone_synth.sv
// Directed bench for note_tone_synth with small dividers so envelopes and
// sample ticks happen within a few dozen cycles.
module tb_note_tone_synth;
    localparam int SW = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] note_period;
    logic [3:0]  volume;
    logic        tone_sq;
    logic        tone_active;
    logic [7:0]  overrun_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    note_tone_synth_if #(.SAMPLE_W(SW)) bus ();

    note_tone_synth #(
        .SAMPLE_W(SW), .AMP_SHIFT(4), .SAMPLE_DIV(8), .ENV_DIV(4), .MIN_PERIOD(4)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .note_period(note_period),
        .volume(volume),
        .smp(bus.master),
        .tone_sq(tone_sq),
        .tone_active(tone_active),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Number of edges until tone_sq next changes, capped at 200.
    task automatic measure_run(output int len);
        logic start;
        start = tone_sq;
        len = 0;
        while (tone_sq == start && len < 200) begin
            step(1);
            len++;
        end
    endtask

    // Hold reset across an edge and release it just after; that edge is edge 0.
    task automatic restart(input logic [18:0] np, input logic [3:0] vol, input logic rdy);
        reset = 1'b1;
        note_period = np;
        volume = vol;
        bus.out_ready = rdy;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        note_period = 19'd10;
        volume = 4'd15;
        bus.out_ready = 1'b1;
        step(3);
        n_cmp++;
        if ({bus.out_valid, bus.out_sample, tone_sq, tone_active, overrun_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got valid=%0b sample=%0h sq=%0b act=%0b ovr=%0d required all 0",
                     bus.out_valid, bus.out_sample, tone_sq, tone_active, overrun_cnt);
        end
    endtask

    task automatic test_steady;
        restart(19'd10, 4'd15, 1'b1);
        step(8);   // edge 8: first tick, amp=1, phase=0
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== 12'hFF0) begin
            n_bad++;
            $display("FAIL first_sample got valid=%0b sample=%0h required 1/ff0", bus.out_valid, bus.out_sample);
        end
        step(1);   // edge 9: accepted
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL accept_clears got %0b required 0", bus.out_valid);
        end
        step(1);   // edge 10
        n_cmp++;
        if (tone_sq !== 1'b0 || tone_active !== 1'b1) begin
            n_bad++;
            $display("FAIL before_toggle got sq=%0b act=%0b required 0/1", tone_sq, tone_active);
        end
        step(1);   // edge 11: first toggle
        n_cmp++;
        if (tone_sq !== 1'b1) begin
            n_bad++;
            $display("FAIL first_toggle got %0b required 1", tone_sq);
        end
        step(9);   // edge 20
        n_cmp++;
        if (tone_sq !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_half got %0b required 1", tone_sq);
        end
        step(1);   // edge 21
        n_cmp++;
        if (tone_sq !== 1'b0) begin
            n_bad++;
            $display("FAIL second_toggle got %0b required 0", tone_sq);
        end
        step(35);  // edge 56: amp=13, phase=1
        n_cmp++;
        if (bus.out_sample !== 12'h0D0) begin
            n_bad++;
            $display("FAIL ramp_sample got %0h required 0d0", bus.out_sample);
        end
        step(8);   // edge 64: amp=15, phase=0
        n_cmp++;
        if (bus.out_sample !== 12'hF10) begin
            n_bad++;
            $display("FAIL full_neg got %0h required f10", bus.out_sample);
        end
        step(8);   // edge 72: amp=15, phase=1
        n_cmp++;
        if (bus.out_sample !== 12'h0F0 || overrun_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL full_pos got sample=%0h ovr=%0d required 0f0/0", bus.out_sample, overrun_cnt);
        end
    endtask

    task automatic test_pitch_change;
        int len;
        step(2);   // edge 74: half_cnt=3 within the 10-cycle half started at 71
        note_period = 19'd6;
        measure_run(len);
        n_cmp++;
        if (len !== 7) begin
            n_bad++;
            $display("FAIL pitch_current_half got %0d required 7", len);
        end
        for (int i = 0; i < 3; i++) begin
            measure_run(len);
            n_cmp++;
            if (len !== 6) begin
                n_bad++;
                $display("FAIL pitch_new_half%0d got %0d required 6", i, len);
            end
        end
    endtask

    task automatic test_rest_release;
        int len;
        logic neg_ok;
        note_period = 19'd0;   // edge 99, phase=1
        measure_run(len);      // boundary at edge 105 forces phase to 0
        n_cmp++;
        if (len !== 6 || tone_sq !== 1'b0 || tone_active !== 1'b0) begin
            n_bad++;
            $display("FAIL rest_boundary got len=%0d sq=%0b act=%0b required 6/0/0", len, tone_sq, tone_active);
        end
        step(7);   // edge 112: amp=14 feeding the tick
        n_cmp++;
        if (bus.out_sample !== 12'hF20) begin
            n_bad++;
            $display("FAIL release_sample got %0h required f20", bus.out_sample);
        end
        neg_ok = 1'b1;
        for (int i = 0; i < 56; i++) begin
            step(1);
            if ($signed(bus.out_sample) > 0) neg_ok = 1'b0;
        end
        n_cmp++;
        if (neg_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL release_nonpositive got %0b required 1", neg_ok);
        end
        n_cmp++;   // edge 168: amp reached 0
        if (bus.out_sample !== 12'h000 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL release_zero got sample=%0h valid=%0b required 000/1", bus.out_sample, bus.out_valid);
        end
        note_period = 19'd2;
        step(20);
        n_cmp++;
        if (tone_active !== 1'b0 || tone_sq !== 1'b0) begin
            n_bad++;
            $display("FAIL short_code_rest got act=%0b sq=%0b required 0/0", tone_active, tone_sq);
        end
    endtask

    task automatic test_backpressure;
        restart(19'd10, 4'd15, 1'b0);
        step(24);  // ticks at 8, 16, 24 with no ready
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== 12'hFF0 || overrun_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL stall got valid=%0b sample=%0h ovr=%0d required 1/ff0/2",
                     bus.out_valid, bus.out_sample, overrun_cnt);
        end
        step(7);   // edge 31
        bus.out_ready = 1'b1;
        step(1);   // edge 32: accept and reload together, amp=7 phase=1
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== 12'h070 || overrun_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL back_to_back got valid=%0b sample=%0h ovr=%0d required 1/070/2",
                     bus.out_valid, bus.out_sample, overrun_cnt);
        end
        step(1);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain got %0b required 0", bus.out_valid);
        end
    endtask

    task automatic test_overrun_saturation;
        bus.out_ready = 1'b0;
        step(2400);
        n_cmp++;
        if (overrun_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL overrun_sat got %0d required 255", overrun_cnt);
        end
        step(80);
        n_cmp++;
        if (overrun_cnt !== 8'd255 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_hold got ovr=%0d valid=%0b required 255/1", overrun_cnt, bus.out_valid);
        end
    endtask

    task automatic test_async_reset;
        int len;
        #3;        // between edges, note playing and sample pending
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.out_sample, tone_sq, tone_active, overrun_cnt} !== '0) begin
            n_bad++;
            $display("FAIL async_reset got valid=%0b sample=%0h sq=%0b act=%0b ovr=%0d required all 0",
                     bus.out_valid, bus.out_sample, tone_sq, tone_active, overrun_cnt);
        end
        note_period = 19'd10;
        bus.out_ready = 1'b1;
        step(1);
        reset = 1'b0;   // edge 0
        step(1);        // edge 1: p_cur loads
        measure_run(len);
        n_cmp++;
        if (len !== 10 || tone_active !== 1'b1 || overrun_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL restart_toggle got len=%0d act=%0b ovr=%0d required 10/1/0", len, tone_active, overrun_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        note_period = '0;
        volume = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_steady();
        test_pitch_change();
        test_rest_release();
        test_backpressure();
        test_overrun_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
